// File: rtl/booth_acc_pkg.sv
// booth_acc_pkg
// Shared definitions for the Booth product accumulator:
//   - state_t    : accumulator FSM states (IDLE, ACCUM, HOLD)
//   - BOOTH_PROD_W / BOOTH_ACC_W : default product and accumulator widths
//   - cnt_width()   : width of the per-block product counter for a given
//                     block length (must be able to hold BLOCK_LEN itself)
package booth_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int BOOTH_PROD_W = 8;
  localparam int BOOTH_ACC_W  = 16;

  // Counter width for a block of block_len products; at least one bit.
  function automatic int cnt_width(input int block_len);
    int w;
    w = $clog2(block_len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/booth_acc_add.sv
// booth_acc_add
// Combinational sign-extend-and-add with signed overflow detection.
// Build option: BOOTH_ACC_SAT_EN
//   defined   : result clamps to the signed limits of ACC_W on overflow
//   undefined : result wraps modulo 2^ACC_W
// In both modes ovf reports that the raw addition overflowed.
// Ports:
//   acc    in  ACC_W   current accumulator value (two's complement)
//   prod   in  PROD_W  signed product to add
//   result out ACC_W   acc + sext(prod), wrapped or saturated
//   ovf    out 1       signed overflow on this addition
module booth_acc_add #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  result,
  output logic              ovf
);

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] raw_sum;

  assign prod_ext[PROD_W-1:0] = prod;

  // Replicate the product sign bit across the upper accumulator bits.
  for (genvar gi = PROD_W; gi < ACC_W; gi++) begin : g_sext
    assign prod_ext[gi] = prod[PROD_W-1];
  end

  assign raw_sum = acc + prod_ext;

  // Same-sign operands producing an opposite-sign result.
  assign ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (raw_sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef BOOTH_ACC_SAT_EN
  localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  // On overflow the operand sign tells which limit was crossed.
  always_comb begin
    result = raw_sum;
    if (ovf) begin
      result = acc[ACC_W-1] ? MIN_NEG : MAX_POS;
    end
  end
`else
  assign result = raw_sum;
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
// Accumulates BLOCK_LEN consecutive signed products into an ACC_W-bit sum
// and presents each completed sum on a valid/ready port.
// Build option: BOOTH_ACC_SAT_EN selects saturating additions (see
// booth_acc_add); when undefined the additions wrap.
// Ports:
//   clk        in  1       clock, rising edge
//   rst        in  1       synchronous active-high reset
//   clr        in  1       synchronous abort of any partial/pending sum
//   prod_valid in  1       product present
//   prod       in  PROD_W  signed product
//   prod_ready out 1       product accepted this cycle (state decode only)
//   sum_valid  out 1       completed sum present
//   sum        out ACC_W   accumulated sum
//   sum_ovf    out 1       overflow/saturation occurred within this block
//   sum_ready  in  1       downstream takes the sum
module booth_product_accumulator
  import booth_acc_pkg::*;
#(
  parameter int PROD_W    = BOOTH_PROD_W,
  parameter int ACC_W     = BOOTH_ACC_W,
  parameter int BLOCK_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              sum_valid,
  output logic [ACC_W-1:0]  sum,
  output logic              sum_ovf,
  input  logic              sum_ready
);

  localparam int CNT_W = cnt_width(BLOCK_LEN);
  // Count value held just before the final product of a block is accepted.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [ACC_W-1:0]   sum_reg, sum_next;
  logic               sum_valid_reg, sum_valid_next;
  logic               sum_ovf_reg, sum_ovf_next;

  logic               accept;
  logic [ACC_W-1:0]   add_a;
  logic [ACC_W-1:0]   add_result;
  logic               add_ovf;

  assign prod_ready = (state_reg != HOLD);
  assign accept     = prod_valid && prod_ready;

  // The first product of a block starts from zero, so a stale accumulator
  // can never leak into the new block.
  assign add_a = (state_reg == IDLE) ? '0 : acc_reg;

  booth_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc    (add_a),
    .prod   (prod),
    .result (add_result),
    .ovf    (add_ovf)
  );

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    count_next     = count_reg;
    sum_next       = sum_reg;
    sum_valid_next = sum_valid_reg;
    sum_ovf_next   = sum_ovf_reg;

    if (clr) begin
      state_next     = IDLE;
      acc_next       = '0;
      count_next     = '0;
      sum_valid_next = 1'b0;
      sum_ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_next     = add_result;
            count_next   = CNT_W'(1);
            // New block: the sticky flag restarts here.
            sum_ovf_next = add_ovf;
            if (BLOCK_LEN == 1) begin
              sum_next       = add_result;
              sum_valid_next = 1'b1;
              state_next     = HOLD;
            end else begin
              state_next = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_next     = add_result;
            count_next   = count_reg + 1'b1;
            sum_ovf_next = sum_ovf_reg | add_ovf;
            if (count_reg == LAST_CNT) begin
              sum_next       = add_result;
              sum_valid_next = 1'b1;
              state_next     = HOLD;
            end
          end
        end
        HOLD: begin
          if (sum_ready) begin
            sum_valid_next = 1'b0;
            acc_next       = '0;
            count_next     = '0;
            state_next     = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      sum_reg       <= '0;
      sum_valid_reg <= 1'b0;
      sum_ovf_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      sum_reg       <= sum_next;
      sum_valid_reg <= sum_valid_next;
      sum_ovf_reg   <= sum_ovf_next;
    end
  end

  assign sum_valid = sum_valid_reg;
  assign sum       = sum_reg;
  assign sum_ovf   = sum_ovf_reg;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Testbench for booth_product_accumulator.
// Three instances: d0 = ACC_W 16 / BLOCK_LEN 4, d1 = ACC_W 9 / BLOCK_LEN 4,
// d2 = ACC_W 16 / BLOCK_LEN 1. Stimulus pushes hand-computed sums into a
// per-instance queue; a monitor per instance pops and compares on each sum
// handshake.
module tb_booth_product_accumulator;

  typedef struct {
    logic [15:0] s;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prod_valid [3];
  logic [7:0]  prod_v     [3];
  logic        sum_ready  [3];
  logic        clr        [3];
  logic        rdy        [3];
  logic        sv         [3];
  logic        ovf        [3];
  logic [15:0] sum_a;
  logic [8:0]  sum_b;
  logic [15:0] sum_c;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .BLOCK_LEN(4)) d0 (
    .clk(clk), .rst(rst), .clr(clr[0]), .prod_valid(prod_valid[0]),
    .prod(prod_v[0]), .prod_ready(rdy[0]), .sum_valid(sv[0]),
    .sum(sum_a), .sum_ovf(ovf[0]), .sum_ready(sum_ready[0]));

  booth_product_accumulator #(.PROD_W(8), .ACC_W(9), .BLOCK_LEN(4)) d1 (
    .clk(clk), .rst(rst), .clr(clr[1]), .prod_valid(prod_valid[1]),
    .prod(prod_v[1]), .prod_ready(rdy[1]), .sum_valid(sv[1]),
    .sum(sum_b), .sum_ovf(ovf[1]), .sum_ready(sum_ready[1]));

  booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .BLOCK_LEN(1)) d2 (
    .clk(clk), .rst(rst), .clr(clr[2]), .prod_valid(prod_valid[2]),
    .prod(prod_v[2]), .prod_ready(rdy[2]), .sum_valid(sv[2]),
    .sum(sum_c), .sum_ovf(ovf[2]), .sum_ready(sum_ready[2]));

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, req, $time);
    end else begin
      $display("ok   %s = %h", nm, act);
    end
  endtask

  function automatic void push(input int d, input logic [15:0] s, input logic o);
    exp_t e;
    e.s = s;
    e.o = o;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Offer one product and return at posedge+1 of the accepting edge,
  // leaving prod_valid high.
  task automatic send(input int d, input logic [7:0] p);
    int n;
    logic ok;
    prod_valid[d] = 1'b1;
    prod_v[d] = p;
    n = 0;
    do begin
      ok = rdy[d];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d got no prod_ready expected ready within 50 cycles", d);
    end
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((qsize(d) != 0 || sv[d]) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (qsize(d) != 0 || sv[d]) begin
      errors++;
      $display("FAIL drain dut%0d got %0d pending expected 0", d, qsize(d));
    end
  endtask

  // Scoreboard monitors: one per instance, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && sv[0] && sum_ready[0]) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL d0_unexpected got sum %h expected no sum", sum_a);
      end else begin
        e = q0.pop_front();
        check("d0_sum", sum_a, e.s);
        check("d0_ovf", {15'd0, ovf[0]}, {15'd0, e.o});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && sv[1] && sum_ready[1]) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected got sum %h expected no sum", sum_b);
      end else begin
        e = q1.pop_front();
        check("d1_sum", {7'd0, sum_b}, e.s);
        check("d1_ovf", {15'd0, ovf[1]}, {15'd0, e.o});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && sv[2] && sum_ready[2]) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL d2_unexpected got sum %h expected no sum", sum_c);
      end else begin
        e = q2.pop_front();
        check("d2_sum", sum_c, e.s);
        check("d2_ovf", {15'd0, ovf[2]}, {15'd0, e.o});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b1_vec [3];
    logic [15:0] b1_exp [3];
    b1_vec[0] = 8'h80; b1_exp[0] = 16'hFF80;
    b1_vec[1] = 8'h05; b1_exp[1] = 16'h0005;
    b1_vec[2] = 8'hFF; b1_exp[2] = 16'hFFFF;

    for (int i = 0; i < 3; i++) begin
      prod_valid[i] = 1'b1;
      prod_v[i]     = 8'h55;
      sum_ready[i]  = 1'b1;
      clr[i]        = 1'b0;
    end

    // Reset held 2 cycles with products offered.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) prod_valid[i] = 1'b0;
    check("rst_prod_ready", {15'd0, rdy[0]}, 16'd1);
    check("rst_sum_valid", {15'd0, sv[0]}, 16'd0);
    check("rst_sum", sum_a, 16'h0000);
    check("rst_sum_ovf", {15'd0, ovf[0]}, 16'd0);

    // Basic block: 4 x -42 = -168.
    push(0, 16'hFF58, 1'b0);
    for (int k = 0; k < 4; k++) begin
      send(0, 8'hD6);
      if (k == 2) check("lat_before_last", {15'd0, sv[0]}, 16'd0);
    end
    prod_valid[0] = 1'b0;
    check("lat_after_last", {15'd0, sv[0]}, 16'd1);
    drain(0);

    // Backpressure: 4 x 1 = 4 held for 5 cycles with products offered.
    sum_ready[0] = 1'b0;
    push(0, 16'h0004, 1'b0);
    for (int k = 0; k < 4; k++) send(0, 8'h01);
    prod_v[0] = 8'h7F;
    for (int k = 0; k < 5; k++) begin
      check("bp_prod_ready", {15'd0, rdy[0]}, 16'd0);
      check("bp_sum_valid", {15'd0, sv[0]}, 16'd1);
      check("bp_sum_stable", sum_a, 16'h0004);
      @(posedge clk);
      #1;
    end
    sum_ready[0] = 1'b1;
    prod_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    check("bp_idle_ready", {15'd0, rdy[0]}, 16'd1);
    check("bp_idle_valid", {15'd0, sv[0]}, 16'd0);
    drain(0);

    // Clear mid-block: partial -84 and the clr-cycle product are discarded.
    push(0, 16'h01FC, 1'b0);
    send(0, 8'hD6);
    send(0, 8'hD6);
    clr[0] = 1'b1;
    prod_v[0] = 8'h11;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    check("clr_sum_valid", {15'd0, sv[0]}, 16'd0);
    for (int k = 0; k < 4; k++) send(0, 8'h7F);
    prod_valid[0] = 1'b0;
    drain(0);

    // Gapped input: same sum as back-to-back.
    push(0, 16'hFF58, 1'b0);
    for (int k = 0; k < 4; k++) begin
      send(0, 8'hD6);
      prod_valid[0] = 1'b0;
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    drain(0);

    // Overflow with ACC_W = 9: 4 x 127.
`ifdef BOOTH_ACC_SAT_EN
    push(1, 16'h00FF, 1'b1);
`else
    push(1, 16'h01FC, 1'b1);
`endif
    for (int k = 0; k < 4; k++) send(1, 8'h7F);
    prod_valid[1] = 1'b0;
    drain(1);
    push(1, 16'h0004, 1'b0);
    for (int k = 0; k < 4; k++) send(1, 8'h01);
    prod_valid[1] = 1'b0;
    drain(1);

    // BLOCK_LEN = 1: each product appears one cycle later, sign-extended.
    for (int k = 0; k < 3; k++) begin
      push(2, b1_exp[k], 1'b0);
      send(2, b1_vec[k]);
      prod_valid[2] = 1'b0;
      check("b1_valid", {15'd0, sv[2]}, 16'd1);
      drain(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
